perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Parametrised bank of event counters for CPU performance monitoring (instructions retired, memory accesses, ECC corrections and future events). Each channel counts single-cycle event pulses with a build-time wrap or saturate policy and sticky overflow flags. An atomic snapshot copies every channel into shadow registers, optionally clearing the live counters. A registered read port lets the debug/CSR logic read shadows one channel at a time.

## Interface
- NUM_CH, 3, number of counter channels (≥1)
- WIDTH, 20, counter width in bits (≥2)
- SATURATE, 0, 0 = wrap at 2^WIDTH, 1 = hold at all-ones
- SEL_W, max(1, clog2(NUM_CH)), read-select width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  global count enable; events ignored while low
- event  in  NUM_CH  per-channel increment pulse, one count per cycle high
- clr  in  NUM_CH  per-channel synchronous clear of live counter and ovf
- snap  in  1  snapshot request, one-cycle pulse
- snap_clear  in  1  sampled with snap; 1 = clear live counters on snapshot
- snap_done  out  1  one-cycle pulse, shadows updated
- rd_en  in  1  read request
- rd_sel  in  SEL_W  channel index to read
- rd_valid  out  1  read data valid, one cycle after rd_en
- rd_data  out  WIDTH  shadow count of selected channel
- rd_ovf  out  1  shadow overflow flag of selected channel
- ovf  out  NUM_CH  live sticky overflow flags

## Operation
- Live state per channel i: cnt[i] (WIDTH), ovf[i]. Shadow state: shd_cnt[i], shd_ovf[i].
- Increment condition inc[i] = enable & event[i].
- Per-cycle live update, in priority order:
  - clr[i], or (snap & snap_clear): cnt[i] ← inc[i] (0 or 1); ovf[i] ← 0. The event in the clear cycle is never lost.
  - Otherwise, inc[i] with cnt[i] == all-ones:
    - SATURATE=0: cnt[i] ← 0, ovf[i] ← 1.
    - SATURATE=1: cnt[i] holds all-ones, ovf[i] ← 1.
  - Otherwise, inc[i]: cnt[i] ← cnt[i] + 1.
  - Otherwise: hold.
- ovf[i] is sticky. Only reset, clr[i], or a clearing snapshot clears it.
- Snapshot, when snap=1 at an edge:
  - For all i, shd_cnt[i] ← cnt[i] and shd_ovf[i] ← ovf[i]. These are pre-update values, so this cycle's events are excluded from the shadow and remain in live.
  - All channels are captured on the same edge (atomic).
  - snap_done = 1 the following cycle.
  - Back-to-back snap pulses are each honoured. snap_done then stays high for consecutive cycles.
- snap_clear is ignored when snap=0.
- Read port:
  - rd_en=1 at an edge: rd_valid ← 1; rd_data/rd_ovf ← shd_cnt/shd_ovf[rd_sel].
  - rd_sel ≥ NUM_CH returns rd_data=0, rd_ovf=0, with rd_valid still 1.
  - rd_en=0: rd_valid ← 0 and rd_data/rd_ovf hold their last value.
- Read and snap on the same edge: the read returns the pre-snapshot shadow.
- Reads are non-destructive and never affect live counters.

## Timing
- Reset (reset_n low, asynchronous): all cnt, ovf, shd_cnt, shd_ovf, rd_data, rd_ovf, rd_valid and snap_done go to 0.
- Deassertion is synchronous to clk, with a deassert synchroniser upstream.
- Reset asserted mid-operation aborts any snapshot or read in flight. No snap_done or rd_valid follows.
- Count latency: event at edge N is visible on cnt/ovf after edge N.
- snap_done and rd_valid: 1-cycle latency, single-cycle pulses per request.
- No backpressure; rd_en may be asserted every cycle for 1/cycle throughput.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Basic count (NUM_CH=3, WIDTH=20): 5 events ch0, 3 ch1, 0 ch2, then snap → snap_done next cycle; reads of sel 0/1/2 return 5/3/0 with rd_ovf=0 and rd_valid one cycle after each rd_en.
- Wrap (WIDTH=4, SATURATE=0): 17 events ch0, then snap and read → rd_data=1, rd_ovf=1. Without snap_clear, live ovf[0] stays 1.
- Saturate (WIDTH=4, SATURATE=1): 20 events ch1 → rd_data=15, rd_ovf=1. A further event leaves the live count at 15.
- Simultaneous events:
  - clr[0] with event[0] at count 9 → live count 1, ovf 0.
  - snap+snap_clear with event at count 7 → shadow 7, live 1.
  - enable=0 with events → counts unchanged.
- Read/snap collision and bad index:
  - rd_en with snap on the same edge → old shadow value.
  - rd_sel=3 with NUM_CH=3 → rd_data=0, rd_valid=1.
- Async reset: assert reset_n low mid-count between edges → all outputs 0 immediately; after release, 2 events then snap/read → 2.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Performance counter bank: per-channel event counters with sticky overflow,
// an atomic snapshot into shadow registers and a registered shadow read port.

// One counter channel: live count, sticky overflow and its shadow copy.
module perf_counter_ch #(
    parameter int WIDTH    = 20,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clear,
    input  logic             snap,
    output logic             ovf,
    output logic [WIDTH-1:0] shd_cnt,
    output logic             shd_ovf
);
    logic [WIDTH-1:0] cnt;

    // Live count update; a clear reloads with this cycle's event so it is never lost.
    // The shadow samples pre-update values, so this cycle's event stays only in live.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            ovf     <= 1'b0;
            shd_cnt <= '0;
            shd_ovf <= 1'b0;
        end else begin
            if (snap) begin
                shd_cnt <= cnt;
                shd_ovf <= ovf;
            end
            if (clear) begin
                cnt <= {{(WIDTH-1){1'b0}}, inc};
                ovf <= 1'b0;
            end else if (inc) begin
                if (&cnt) begin
                    ovf <= 1'b1;
                    if (!SATURATE) cnt <= '0;
                end else begin
                    cnt <= cnt + WIDTH'(1);
                end
            end
        end
    end
endmodule

module perf_counter_bank #(
    parameter  int NUM_CH   = 3,
    parameter  int WIDTH    = 20,
    parameter  bit SATURATE = 1'b0,
    localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    // per-channel event pulses (named "events": "event" is a reserved word)
    input  logic [NUM_CH-1:0] events,
    input  logic [NUM_CH-1:0] clr,
    input  logic              snap,
    input  logic              snap_clear,
    output logic              snap_done,
    input  logic              rd_en,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic              rd_valid,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_ovf,
    output logic [NUM_CH-1:0] ovf
);
    logic [NUM_CH-1:0]            inc;
    logic [NUM_CH-1:0]            clear;
    logic [NUM_CH-1:0][WIDTH-1:0] shd_cnt;
    logic [NUM_CH-1:0]            shd_ovf;
    logic [WIDTH-1:0]             sel_cnt;
    logic                         sel_ovf;

    assign inc   = {NUM_CH{enable}} & events;
    assign clear = clr | {NUM_CH{snap & snap_clear}};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        perf_counter_ch #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .inc     (inc[i]),
            .clear   (clear[i]),
            .snap    (snap),
            .ovf     (ovf[i]),
            .shd_cnt (shd_cnt[i]),
            .shd_ovf (shd_ovf[i])
        );
    end

    // Shadow select; an index past the last channel reads as zero.
    always_comb begin
        sel_cnt = '0;
        sel_ovf = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                sel_cnt = shd_cnt[i];
                sel_ovf = shd_ovf[i];
            end
        end
    end

    // Registered read port; data holds between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_ovf   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= sel_cnt;
                rd_ovf  <= sel_ovf;
            end
        end
    end

    // One done pulse per snapshot request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) snap_done <= 1'b0;
        else          snap_done <= snap;
    end
endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench: a wrapping and a saturating bank driven with identical
// stimulus; expectations come from an arithmetic model of the counting rules.
module tb_perf_counter_bank;
    localparam int NUM_CH = 3;
    localparam int WIDTH  = 4;
    localparam int SEL_W  = 2;
    localparam int MAXV   = (1 << WIDTH) - 1;

    logic clk = 0, reset_n = 0, enable = 0, snap = 0, snap_clear = 0, rd_en = 0;
    logic [NUM_CH-1:0] events = '0, clr = '0;
    logic [SEL_W-1:0]  rd_sel = '0;
    logic [1:0]        snap_done, rd_valid, rd_ovf;
    logic [1:0][WIDTH-1:0]  rd_data;
    logic [1:0][NUM_CH-1:0] ovf;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .enable(enable), .events(events), .clr(clr),
        .snap(snap), .snap_clear(snap_clear), .snap_done(snap_done[0]),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_valid(rd_valid[0]),
        .rd_data(rd_data[0]), .rd_ovf(rd_ovf[0]), .ovf(ovf[0]));

    perf_counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable), .events(events), .clr(clr),
        .snap(snap), .snap_clear(snap_clear), .snap_done(snap_done[1]),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_valid(rd_valid[1]),
        .rd_data(rd_data[1]), .rd_ovf(rd_ovf[1]), .ovf(ovf[1]));

    typedef struct packed {
        logic                   sdone;
        logic                   rvld;
        logic [1:0][WIDTH-1:0]  rdata;
        logic [1:0]             rovf;
        logic [1:0][NUM_CH-1:0] ovf;
    } cyc_t;
    typedef struct packed {
        logic [1:0][WIDTH-1:0] d;
        logic [1:0]            o;
    } rd_t;

    cyc_t cyc_q[$];
    rd_t  rd_q[$];
    int   errors = 0, checks = 0;
    bit   mon_on = 0;

    // model state: index 0 = wrapping bank, 1 = saturating bank
    int m_cnt[2][NUM_CH];
    bit m_ovf[2][NUM_CH];
    int m_shd[2][NUM_CH];
    bit m_shdovf[2][NUM_CH];
    int m_rd[2];
    bit m_rdovf[2];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_rd[k] = 0; m_rdovf[k] = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_cnt[k][i] = 0; m_ovf[k][i] = 0; m_shd[k][i] = 0; m_shdovf[k][i] = 0;
            end
        end
    endtask

    // Advance the model across the coming rising edge and queue expectations.
    task automatic model_step();
        cyc_t e;
        rd_t  r;
        bit   inc;
        e = '0;
        r = '0;
        if (!reset_n) begin
            m_reset();
            cyc_q.push_back(e);
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (rd_en) begin
                if (int'(rd_sel) < NUM_CH) begin
                    m_rd[k] = m_shd[k][rd_sel]; m_rdovf[k] = m_shdovf[k][rd_sel];
                end else begin
                    m_rd[k] = 0; m_rdovf[k] = 0;
                end
            end
            if (snap)
                for (int i = 0; i < NUM_CH; i++) begin
                    m_shd[k][i] = m_cnt[k][i]; m_shdovf[k][i] = m_ovf[k][i];
                end
            for (int i = 0; i < NUM_CH; i++) begin
                inc = enable && events[i];
                if (clr[i] || (snap && snap_clear)) begin
                    m_cnt[k][i] = inc ? 1 : 0;
                    m_ovf[k][i] = 0;
                end else if (inc) begin
                    if (m_cnt[k][i] + 1 > MAXV) m_ovf[k][i] = 1;
                    if (k == 0) m_cnt[k][i] = (m_cnt[k][i] + 1) % (MAXV + 1);
                    else if (m_cnt[k][i] < MAXV) m_cnt[k][i]++;
                end
                e.ovf[k][i] = m_ovf[k][i];
            end
            e.rdata[k] = WIDTH'(m_rd[k]);
            e.rovf[k]  = m_rdovf[k];
            r.d[k]     = WIDTH'(m_rd[k]);
            r.o[k]     = m_rdovf[k];
        end
        e.sdone = snap;
        e.rvld  = rd_en;
        if (rd_en) rd_q.push_back(r);
        cyc_q.push_back(e);
    endtask

    task automatic drive(bit en, bit [NUM_CH-1:0] ev, bit [NUM_CH-1:0] c,
                         bit s, bit sc, bit r, bit [SEL_W-1:0] sel);
        enable = en; events = ev; clr = c; snap = s; snap_clear = sc;
        rd_en = r; rd_sel = sel;
        model_step();
    endtask

    task automatic cyc(bit en, bit [NUM_CH-1:0] ev, bit [NUM_CH-1:0] c,
                       bit s, bit sc, bit r, bit [SEL_W-1:0] sel);
        @(negedge clk);
        drive(en, ev, c, s, sc, r, sel);
    endtask

    task automatic idle(int n);
        for (int j = 0; j < n; j++) cyc(1, '0, '0, 0, 0, 0, '0);
    endtask

    task automatic chk_zero(string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_snap_done"}, 32'(snap_done[k]), 0);
            chk({tag, "_rd_valid"},  32'(rd_valid[k]), 0);
            chk({tag, "_rd_data"},   32'(rd_data[k]), 0);
            chk({tag, "_rd_ovf"},    32'(rd_ovf[k]), 0);
            chk({tag, "_ovf"},       32'(ovf[k]), 0);
        end
    endtask

    // Monitor: pops one expectation per cycle, and a read result whenever rd_valid is seen.
    initial begin
        cyc_t e;
        rd_t  r;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                if (cyc_q.size() == 0) chk("cycle_queue_empty", 1, 0);
                else begin
                    e = cyc_q.pop_front();
                    for (int k = 0; k < 2; k++) begin
                        chk($sformatf("snap_done[%0d]", k), 32'(snap_done[k]), 32'(e.sdone));
                        chk($sformatf("rd_valid[%0d]", k),  32'(rd_valid[k]), 32'(e.rvld));
                        chk($sformatf("ovf[%0d]", k),       32'(ovf[k]), 32'(e.ovf[k]));
                        chk($sformatf("rd_data_hold[%0d]", k), 32'(rd_data[k]), 32'(e.rdata[k]));
                    end
                end
                if (rd_valid[0] === 1'b1) begin
                    if (rd_q.size() == 0) chk("unexpected_rd_valid", 1, 0);
                    else begin
                        r = rd_q.pop_front();
                        for (int k = 0; k < 2; k++) begin
                            chk($sformatf("rd_data[%0d]", k), 32'(rd_data[k]), 32'(r.d[k]));
                            chk($sformatf("rd_ovf[%0d]", k),  32'(rd_ovf[k]), 32'(r.o[k]));
                        end
                    end
                end
            end
        end
    end

    initial begin
        m_reset();
        @(negedge clk);
        chk_zero("reset");
        mon_on = 1;
        drive(0, '0, '0, 0, 0, 0, '0);
        @(negedge clk);
        reset_n = 1;
        drive(0, '0, '0, 0, 0, 0, '0);

        // basic count: 5 on ch0, 3 on ch1, none on ch2
        for (int i = 0; i < 5; i++) cyc(1, {1'b0, (i < 3), 1'b1}, '0, 0, 0, 0, '0);
        cyc(1, '0, '0, 1, 0, 0, '0);
        for (int s = 0; s < 3; s++) cyc(1, '0, '0, 0, 0, 1, SEL_W'(s));
        idle(1);

        // wrap / saturate on ch0: 17 events
        cyc(1, '0, '1, 0, 0, 0, '0);
        for (int i = 0; i < 17; i++) cyc(1, 3'b001, '0, 0, 0, 0, '0);
        cyc(1, '0, '0, 1, 0, 0, '0);
        cyc(1, '0, '0, 0, 0, 1, 2'd0);
        idle(2);

        // saturate on ch1: 20 events, snap, read, one more event
        for (int i = 0; i < 20; i++) cyc(1, 3'b010, '0, 0, 0, 0, '0);
        cyc(1, '0, '0, 1, 0, 0, '0);
        cyc(1, 3'b010, '0, 0, 0, 1, 2'd1);
        cyc(1, '0, '0, 1, 0, 0, '0);
        cyc(1, '0, '0, 0, 0, 1, 2'd1);

        // clr with event at count 9
        cyc(1, '0, '1, 0, 0, 0, '0);
        for (int i = 0; i < 9; i++) cyc(1, 3'b001, '0, 0, 0, 0, '0);
        cyc(1, 3'b001, 3'b001, 0, 0, 0, '0);
        cyc(1, '0, '0, 1, 0, 0, '0);
        cyc(1, '0, '0, 0, 0, 1, 2'd0);

        // clearing snapshot with event at count 7 on ch2
        cyc(1, '0, '1, 0, 0, 0, '0);
        for (int i = 0; i < 7; i++) cyc(1, 3'b100, '0, 0, 0, 0, '0);
        cyc(1, 3'b100, '0, 1, 1, 0, '0);
        cyc(1, '0, '0, 0, 0, 1, 2'd2);
        cyc(1, '0, '0, 1, 0, 0, '0);
        cyc(1, '0, '0, 0, 0, 1, 2'd2);

        // disabled events
        for (int i = 0; i < 3; i++) cyc(0, '1, '0, 0, 0, 0, '0);
        cyc(1, '0, '0, 1, 0, 0, '0);
        for (int s = 0; s < 3; s++) cyc(1, '0, '0, 0, 0, 1, SEL_W'(s));

        // read/snap collision, bad index, back-to-back snaps
        cyc(1, 3'b001, '0, 0, 0, 0, '0);
        cyc(1, 3'b001, '0, 1, 0, 1, 2'd0);
        cyc(1, '0, '0, 0, 0, 1, 2'd0);
        cyc(1, '0, '0, 0, 0, 1, 2'd3);
        cyc(1, 3'b011, '0, 1, 0, 0, '0);
        cyc(1, 3'b011, '0, 1, 0, 0, '0);
        cyc(1, '0, '0, 1, 0, 1, 2'd1);
        idle(1);

        // async reset mid-count with snap and read in flight
        cyc(1, 3'b111, '0, 0, 0, 1, 2'd1);
        cyc(1, 3'b111, '0, 1, 0, 1, 2'd0);
        #2;
        reset_n = 0;
        #1;
        chk_zero("async_reset");
        cyc_q.delete();
        rd_q.delete();
        m_reset();
        cyc_q.push_back('0);
        cyc(1, '1, '0, 1, 0, 1, '0);
        cyc(1, '1, '0, 0, 0, 0, '0);
        @(negedge clk);
        reset_n = 1;
        drive(1, 3'b001, '0, 0, 0, 0, '0);
        cyc(1, 3'b001, '0, 0, 0, 0, '0);
        cyc(1, '0, '0, 1, 0, 0, '0);
        cyc(1, '0, '0, 0, 0, 1, 2'd0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            bit [NUM_CH-1:0] ev, c;
            for (int i = 0; i < NUM_CH; i++) begin
                ev[i] = ($urandom_range(0, 99) < 60);
                c[i]  = ($urandom_range(0, 99) < 3);
            end
            cyc(($urandom_range(0, 9) != 0), ev, c, ($urandom_range(0, 99) < 8),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                SEL_W'($urandom_range(0, 3)));
        end
        idle(3);
        @(posedge clk);
        #2;
        mon_on = 0;
        chk("cycle_queue_drained", 32'(cyc_q.size()), 0);
        chk("read_queue_drained", 32'(rd_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
